// File: rtl/y_response_capture.sv
// Captures DUT result frames, folds them into a 32-bit MISR signature and
// streams buffered frames out byte-by-byte over a valid/ready handshake.
module y_response_capture #(
  parameter int Y_WIDTH = 360,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [Y_WIDTH-1:0] y_in,
  input  logic               y_valid,
  input  logic               sig_clr,
  output logic [7:0]         out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic [31:0]        sig,
  output logic [15:0]        frame_cnt,
  output logic               overflow,
  output logic               busy
);

  localparam int NBYTES = Y_WIDTH / 8;
  localparam int KW     = $clog2(NBYTES);
  localparam int NCHUNK = (Y_WIDTH + 31) / 32;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [Y_WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic [Y_WIDTH-1:0]   shreg;
  logic [KW-1:0]        k;
  logic                 empty, full, last_byte, accept, pop, push, drop;
  logic [NCHUNK*32-1:0] y_ext;
  logic [31:0]          fold, fb_sig;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign last_byte = (k == KW'(NBYTES - 1));
  assign accept    = out_valid && out_ready;
  // A pop on the final byte frees a slot, so a push while full still lands.
  assign pop       = !empty && ((state_q == IDLE) || (accept && last_byte));
  assign push      = y_valid && (!full || pop);
  assign drop      = y_valid && full && !pop;
  assign busy      = !empty || (state_q == SEND);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= y_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = shreg[7:0];
    case (state_q)
      IDLE: if (!empty) state_d = SEND;
      SEND: begin
        out_valid = 1'b1;
        out_last  = last_byte;
        if (accept && last_byte && empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg   <= '0;
      k       <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        shreg <= mem[rd_ptr];
        k     <= '0;
      end else if (accept) begin
        shreg <= shreg >> 8;
        k     <= k + KW'(1);
      end
    end
  end

  always_comb begin
    y_ext                = '0;
    y_ext[Y_WIDTH-1:0]   = y_in;
    fold                 = '0;
    for (int i = 0; i < NCHUNK; i++) fold ^= y_ext[i*32 +: 32];
    fb_sig = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ fold;
  end

  // Frames are signed and counted even when the FIFO drops them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig       <= 32'hFFFF_FFFF;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else if (sig_clr) begin
      sig       <= 32'hFFFF_FFFF;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (y_valid) begin
        sig <= fb_sig;
        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_y_response_capture.sv
// Randomised and directed bench for y_response_capture against a queue-based
// reference of the frame buffer, byte stream and MISR signature.
module tb_y_response_capture;

  localparam int YW    = 360;
  localparam int NB    = YW / 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [YW-1:0] y_in = '0;
  logic          y_valid = 1'b0;
  logic          sig_clr = 1'b0;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_valid, out_last, overflow, busy;
  logic [31:0]   sig;
  logic [15:0]   frame_cnt;

  int nChecks = 0;
  int nPass   = 0;

  logic [YW-1:0] m_q[$];
  logic [YW-1:0] m_cur = '0;
  bit            m_act = 1'b0;
  int            m_idx = 0;
  logic [31:0]   m_sig = 32'hFFFF_FFFF;
  logic [15:0]   m_cnt = '0;
  bit            m_ovf = 1'b0;
  logic [7:0]    byteLog[$];

  y_response_capture #(.Y_WIDTH(YW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .y_valid(y_valid), .sig_clr(sig_clr),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .sig(sig), .frame_cnt(frame_cnt),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] foldFrame(input logic [YW-1:0] f);
    logic [383:0] w;
    logic [31:0]  r;
    w = 384'(f);
    r = '0;
    for (int i = 0; i < 12; i++) r ^= w[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [31:0] misrStep(input logic [31:0] s, input logic [YW-1:0] f);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb} ^ foldFrame(f);
  endfunction

  // Reference: a queue of stored frames plus the frame being sent and its byte index.
  task automatic modelStep();
    int pre;
    bit actPre, fin, popping, pushOk;
    if (!rst_n) begin
      m_q.delete();
      m_act = 1'b0; m_idx = 0; m_cur = '0;
      m_sig = 32'hFFFF_FFFF; m_cnt = '0; m_ovf = 1'b0;
      return;
    end
    pre     = m_q.size();
    actPre  = m_act;
    fin     = actPre && out_ready && (m_idx == NB - 1);
    popping = (pre > 0) && (!actPre || fin);
    pushOk  = y_valid && ((pre < DEPTH) || popping);
    if (actPre && out_ready) begin
      if (fin) m_act = 1'b0;
      else m_idx++;
    end
    if (popping) begin
      m_cur = m_q.pop_front();
      m_act = 1'b1;
      m_idx = 0;
    end
    if (pushOk) m_q.push_back(y_in);
    if (sig_clr) begin
      m_sig = 32'hFFFF_FFFF; m_cnt = '0; m_ovf = 1'b0;
    end else begin
      if (y_valid) begin
        m_sig = misrStep(m_sig, y_in);
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      if (y_valid && !pushOk) m_ovf = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    checkOutput("out_valid", 32'(out_valid), 32'(m_act));
    if (m_act) begin
      checkOutput("out_data", 32'(out_data), 32'(m_cur[m_idx*8 +: 8]));
      checkOutput("out_last", 32'(out_last), 32'(m_idx == NB - 1));
    end
    checkOutput("sig", sig, m_sig);
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("busy", 32'(busy), 32'(m_act || (m_q.size() > 0)));
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) byteLog.push_back(out_data);
  end

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit v, input logic [YW-1:0] d, input bit rdy, input bit clr);
    y_valid   = v;
    y_in      = d;
    out_ready = rdy;
    sig_clr   = clr;
  endtask

  task automatic waitIdle(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      stepCycle();
      if (!busy) break;
    end
    checkOutput("wait_idle", 32'(busy), 32'd0);
  endtask

  function automatic logic [YW-1:0] randFrame();
    logic [383:0] t;
    for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
    return t[YW-1:0];
  endfunction

  initial begin
    logic [YW-1:0] ones;
    int bad, saved;
    ones = '1;

    #1 rst_n = 1'b0;
    repeat (3) stepCycle();
    rst_n = 1'b1;
    stepCycle();
    checkOutput("rst_sig", sig, 32'hFFFF_FFFF);
    checkOutput("rst_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);

    byteLog.delete();
    applyStimulus(1'b1, '0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("zero_sig", sig, 32'hFFFF_FFFE);
    checkOutput("zero_cnt", 32'(frame_cnt), 32'd1);
    waitIdle(100);
    bad = 0;
    foreach (byteLog[i]) if (byteLog[i] != 8'h00) bad++;
    checkOutput("zero_len", 32'(byteLog.size()), 32'd45);
    checkOutput("zero_bytes", 32'(bad), 32'd0);

    byteLog.delete();
    applyStimulus(1'b1, YW'(24'h030201), 1'b1, 1'b0);
    stepCycle();
    y_valid = 1'b0;
    stepCycle();
    stepCycle();
    out_ready = 1'b0;
    stepCycle();
    checkOutput("stall_data1", 32'(out_data), 32'h02);
    stepCycle();
    checkOutput("stall_data2", 32'(out_data), 32'h02);
    out_ready = 1'b1;
    waitIdle(100);
    checkOutput("order_b0", 32'(byteLog[0]), 32'h01);
    checkOutput("order_b1", 32'(byteLog[1]), 32'h02);
    checkOutput("order_b2", 32'(byteLog[2]), 32'h03);
    checkOutput("order_b3", 32'(byteLog[3]), 32'h00);

    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    stepCycle();
    for (int t = 1; t <= 6; t++) begin
      applyStimulus(1'b1, YW'(t), 1'b0, 1'b0);
      stepCycle();
    end
    y_valid = 1'b0;
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_cnt", 32'(frame_cnt), 32'd6);
    byteLog.delete();
    out_ready = 1'b1;
    waitIdle(400);
    checkOutput("ovf_len", 32'(byteLog.size()), 32'd225);
    for (int i = 0; i < 5; i++)
      if (byteLog.size() > 45 * i) checkOutput("ovf_tag", 32'(byteLog[45*i]), 32'(i + 1));

    byteLog.delete();
    applyStimulus(1'b1, ones, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("clr_sig", sig, 32'hFFFF_FFFF);
    checkOutput("clr_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("clr_ovf", 32'(overflow), 32'd0);
    waitIdle(100);
    bad = 0;
    foreach (byteLog[i]) if (byteLog[i] != 8'hFF) bad++;
    checkOutput("clr_len", 32'(byteLog.size()), 32'd45);
    checkOutput("clr_bytes", 32'(bad), 32'd0);

    for (int c = 0; c < 1500; c++) begin
      bit burst;
      burst = (c / 300) % 2 == 1;
      applyStimulus($urandom_range(0, 9) < (burst ? 6 : 2), randFrame(),
                    burst ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 99) == 0);
      stepCycle();
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    waitIdle(500);

    byteLog.delete();
    applyStimulus(1'b1, randFrame(), 1'b1, 1'b0);
    stepCycle();
    y_valid = 1'b0;
    for (int i = 0; i < 60 && byteLog.size() < 11; i++) stepCycle();
    checkOutput("mid_progress", 32'(byteLog.size() >= 11), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    saved = byteLog.size();
    repeat (6) stepCycle();
    checkOutput("mid_residual", 32'(byteLog.size()), 32'(saved));
    checkOutput("mid_busy_after", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
